time_display_driver: RTL and testbench
======================================

TIME_DISPLAY_DRIVER -- requirements
Module: time_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal minimum 16.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1: 1 = seg/dp/an driven active-low; 0 = active-high.
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port timeBus  input  24  packed time; hours=[20:16], minutes=[13:8], seconds=[5:0]; bits [23:21],[15:14],[7:6] ignored.
REQ-006 Port blank  input  1  1 = all digits dark.
REQ-007 Port seg  output  7  segment drive, seg[0]=a ... seg[6]=g.
REQ-008 Port dp  output  1  decimal-point drive.
REQ-009 Port an  output  6  one-hot digit enable; an[0]=seconds units, an[1]=seconds tens, an[2]=minutes units, an[3]=minutes tens, an[4]=hours units, an[5]=hours tens.
REQ-010 Port busy  output  1  high while the conversion FSM is not IDLE.

Function
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count, digit index (0..5) SHALL advance, wrapping 5->0.
REQ-012 frame_start SHALL be the prescaler terminal cycle with index==5; a start_pending flag, set by reset, SHALL also request conversion.
REQ-013 Conversion FSM states: IDLE -> LOAD (on frame_start or start_pending; clears start_pending) -> CONV (exactly 6 cycles) -> DONE (1 cycle) -> IDLE.
REQ-014 LOAD SHALL capture timeBus once; timeBus changes during CONV/DONE SHALL NOT affect the current result.
REQ-015 CONV SHALL run shift-add-3 binary-to-BCD on all three fields in parallel, 6 iterations; hours zero-extended to 6 bits.
REQ-016 DONE SHALL update all six display digit registers in the same cycle (no partially updated frame).
REQ-017 Latency: request to display-register update = 8 cycles (LOAD 1, CONV 6, DONE 1).
REQ-018 A field out of range (seconds or minutes >59, hours >23) SHALL show dash on both of its digits; other fields unaffected.
REQ-019 Decode before polarity, hex over seg[6:0]: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F, dash=40; SEG_ACTIVE_LOW inverts seg, dp and an.
REQ-020 seg, dp and an SHALL be registered and SHALL reflect a new index one cycle after the index changes.
REQ-021 dp SHALL be lit only at index 2 and index 4.
REQ-022 blank=1 SHALL force all an, seg and dp inactive on the next cycle; prescaler, index and conversion SHALL continue unaffected.
REQ-023 Leading zeros SHALL be displayed (hours 5 shows "05").

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, set: prescaler 0, index 0, display digits all 0, FSM IDLE, start_pending 1, busy 0, and an/seg/dp inactive.
REQ-025 rst asserted mid-conversion SHALL abort the conversion; no partial result is written.
REQ-026 The first conversion SHALL start on the first clk edge after rst deasserts.

Verification (SCAN_DIV=16, SEG_ACTIVE_LOW=1)
REQ-027 Release reset with timeBus=hours 13, minutes 45, seconds 07 -> busy high for 8 cycles; digits {1,3,4,5,0,7}; at index 0: an=6'b111110, seg=~07=7'h78.
REQ-028 timeBus=23:59:59 -> digits {2,3,5,9,5,9}; dp=0 only while an[2] or an[4] is active.
REQ-029 seconds=60, minutes=12, hours=8 -> an[0]/an[1] slots seg=7'h3F (dash); remaining digits show 0,8,1,2.
REQ-030 Change timeBus 3 cycles into CONV -> display holds the LOAD-sampled value until the DONE of the next frame.
REQ-031 blank=1 for 100 cycles -> an=6'h3F, seg=7'h7F, dp=1 throughout; busy still pulses at each frame_start.
REQ-032 Assert rst asynchronously in the 4th CONV cycle -> outputs go to reset values before the next edge; after release, a fresh 8-cycle conversion completes.

Source files
------------

// File: rtl/time_display_driver.sv
// time_display_driver: six-digit multiplexed HH:MM:SS display with a per-frame BCD conversion FSM
module time_display_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] timeBus,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic        busy
);
  localparam int   PW   = $clog2(SCAN_DIV);
  localparam logic INV  = SEG_ACTIVE_LOW != 0;
  localparam logic [3:0] DASH = 4'hA;
  typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q, cnt_q;
  logic          start_pend_q;
  logic [13:0]   sec_q, min_q, hr_q;
  logic [2:0]    bad_q;
  logic [3:0]    dig_q [6];
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [5:0]    an_q;
  logic          tc, frame_start;
  logic [3:0]    cur;
  logic          unused_bits;
  // one shift-add-3 iteration on {tens, units, remaining binary}
  function automatic logic [13:0] dd_step(input logic [13:0] v);
    logic [13:0] t;
    t = {v[13:10] >= 4'd5 ? v[13:10] + 4'd3 : v[13:10],
         v[9:6]   >= 4'd5 ? v[9:6]   + 4'd3 : v[9:6], v[5:0]};
    return {t[12:0], 1'b0};
  endfunction
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
  assign tc          = presc_q == PW'(SCAN_DIV - 1);
  assign frame_start = tc && idx_q == 3'd5;
  assign cur         = dig_q[idx_q];
  assign busy        = state_q != IDLE;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign unused_bits = ^{timeBus[23:21], timeBus[15:14], timeBus[7:6]};
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = (frame_start || start_pend_q) ? LOAD : IDLE;
      LOAD: state_d = CONV;
      CONV: state_d = cnt_q == 3'd5 ? DONE : CONV;
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      start_pend_q <= 1'b1;
      sec_q        <= '0;
      min_q        <= '0;
      hr_q         <= '0;
      bad_q        <= '0;
      dig_q        <= '{default: 4'd0};
      seg_q        <= {7{INV}};
      dp_q         <= INV;
      an_q         <= {6{INV}};
    end else begin
      state_q <= state_d;
      presc_q <= tc ? '0 : presc_q + 1'b1;
      if (tc) idx_q <= idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
      if (state_q == LOAD) begin
        start_pend_q <= 1'b0;
        cnt_q        <= '0;
        sec_q        <= {8'd0, timeBus[5:0]};
        min_q        <= {8'd0, timeBus[13:8]};
        hr_q         <= {9'd0, timeBus[20:16]};
        bad_q        <= {timeBus[20:16] > 5'd23, timeBus[13:8] > 6'd59, timeBus[5:0] > 6'd59};
      end
      if (state_q == CONV) begin
        cnt_q <= cnt_q + 3'd1;
        sec_q <= dd_step(sec_q);
        min_q <= dd_step(min_q);
        hr_q  <= dd_step(hr_q);
      end
      if (state_q == DONE)
        dig_q <= '{bad_q[0] ? DASH : sec_q[9:6], bad_q[0] ? DASH : sec_q[13:10],
                   bad_q[1] ? DASH : min_q[9:6], bad_q[1] ? DASH : min_q[13:10],
                   bad_q[2] ? DASH : hr_q[9:6],  bad_q[2] ? DASH : hr_q[13:10]};
      seg_q <= (blank ? 7'd0 : dec(cur)) ^ {7{INV}};
      an_q  <= (blank ? 6'd0 : 6'd1 << idx_q) ^ {6{INV}};
      dp_q  <= (!blank && (idx_q == 3'd2 || idx_q == 3'd4)) ^ INV;
    end
  end
endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver: directed checks of scanning, conversion, range dashes, blanking and async reset
module tb_time_display_driver;
  logic        clk = 1'b0, rst = 1'b1, blank = 1'b0;
  logic [23:0] timeBus = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        busy;
  int          checks = 0, passed = 0;
  logic [6:0]  seen_seg [6];
  logic        seen_dp [6];
  logic [5:0]  seen;
  logic [6:0]  exp_seg [6];
  // active-low segment patterns for digits 0..9 and dash (index 10)
  localparam logic [6:0] AL [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                     7'h02, 7'h78, 7'h00, 7'h10, 7'h3F};

  time_display_driver #(.SCAN_DIV(16), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .timeBus(timeBus), .blank(blank),
    .seg(seg), .dp(dp), .an(an), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [23:0] tpack(input int h, input int m, input int s);
    return {3'd0, 5'(h), 2'd0, 6'(m), 2'd0, 6'(s)};
  endfunction

  task automatic set_exp(input int d5, input int d4, input int d3, input int d2, input int d1, input int d0);
    exp_seg[0] = AL[d0]; exp_seg[1] = AL[d1]; exp_seg[2] = AL[d2];
    exp_seg[3] = AL[d3]; exp_seg[4] = AL[d4]; exp_seg[5] = AL[d5];
  endtask

  task automatic capture_frame();
    seen = '0;
    repeat (96) @(negedge clk)
      for (int i = 0; i < 6; i++)
        if (an == ~(6'd1 << i) && !seen[i]) begin
          seen_seg[i] = seg;
          seen_dp[i]  = dp;
          seen[i]     = 1'b1;
        end
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      ok = busy === lvl;
    end
  endtask

  task automatic wait_done(output bit ok);
    bit a, b, c;
    wait_busy(1'b0, 20, a);
    wait_busy(1'b1, 250, b);
    wait_busy(1'b0, 20, c);
    ok = a && b && c;
  endtask

  task automatic test_reset();
    int cnt;
    timeBus = tpack(13, 45, 7);
    repeat (3) @(negedge clk);
    checks++; if (an !== 6'h3F) $display("FAIL reset_an got %h expected 3f", an); else passed++;
    checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h expected 7f", seg); else passed++;
    checks++; if (dp !== 1'b1) $display("FAIL reset_dp got %b expected 1", dp); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL first_edge_busy got %b expected 1", busy); else passed++;
    checks++; if (an !== 6'b111110) $display("FAIL first_edge_an got %b expected 111110", an); else passed++;
    checks++; if (seg !== 7'h40) $display("FAIL first_edge_seg got %h expected 40", seg); else passed++;
    cnt = 1;
    repeat (19) @(negedge clk) if (busy) cnt++;
    checks++; if (cnt != 8) $display("FAIL busy_len got %0d expected 8", cnt); else passed++;
    capture_frame();
    set_exp(1, 3, 4, 5, 0, 7);
    checks++; if (seen !== 6'h3F) $display("FAIL conv_slots got %b expected 111111", seen); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seen_seg[i] !== exp_seg[i]) $display("FAIL conv_seg slot%0d got %h expected %h", i, seen_seg[i], exp_seg[i]);
      else passed++;
    end
  endtask

  task automatic test_dp();
    bit ok;
    timeBus = tpack(23, 59, 59);
    wait_done(ok);
    checks++; if (!ok) $display("FAIL dp_wait got timeout expected conversion"); else passed++;
    capture_frame();
    set_exp(2, 3, 5, 9, 5, 9);
    checks++; if (seen !== 6'h3F) $display("FAIL max_slots got %b expected 111111", seen); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seen_seg[i] !== exp_seg[i]) $display("FAIL max_seg slot%0d got %h expected %h", i, seen_seg[i], exp_seg[i]);
      else passed++;
      checks++;
      if (seen_dp[i] !== ((i == 2 || i == 4) ? 1'b0 : 1'b1))
        $display("FAIL dp slot%0d got %b expected %b", i, seen_dp[i], (i == 2 || i == 4) ? 1'b0 : 1'b1);
      else passed++;
    end
  endtask

  task automatic test_range();
    bit ok;
    for (int c = 0; c < 2; c++) begin
      timeBus = c == 0 ? tpack(8, 12, 60) : tpack(24, 60, 59);
      if (c == 0) set_exp(0, 8, 1, 2, 10, 10); else set_exp(10, 10, 10, 10, 5, 9);
      wait_done(ok);
      checks++; if (!ok) $display("FAIL range_wait case%0d got timeout expected conversion", c); else passed++;
      capture_frame();
      checks++; if (seen !== 6'h3F) $display("FAIL range_slots case%0d got %b expected 111111", c, seen); else passed++;
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seen_seg[i] !== exp_seg[i]) $display("FAIL range_seg case%0d slot%0d got %h expected %h", c, i, seen_seg[i], exp_seg[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_capture();
    bit a, b, ok;
    timeBus = tpack(1, 2, 3);
    wait_busy(1'b0, 20, a);
    wait_busy(1'b1, 250, b);
    checks++; if (!(a && b)) $display("FAIL cap_start got timeout expected conversion"); else passed++;
    repeat (3) @(negedge clk);
    timeBus = tpack(10, 20, 30);
    for (int f = 0; f < 2; f++) begin
      if (f == 0) wait_busy(1'b0, 20, ok); else wait_done(ok);
      checks++; if (!ok) $display("FAIL cap_wait frame%0d got timeout expected conversion", f); else passed++;
      capture_frame();
      if (f == 0) set_exp(0, 1, 0, 2, 0, 3); else set_exp(1, 0, 2, 0, 3, 0);
      checks++; if (seen !== 6'h3F) $display("FAIL cap_slots frame%0d got %b expected 111111", f, seen); else passed++;
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seen_seg[i] !== exp_seg[i]) $display("FAIL cap_seg frame%0d slot%0d got %h expected %h", f, i, seen_seg[i], exp_seg[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_blank();
    int bad, rises;
    logic prev;
    bad = 0; rises = 0;
    blank = 1'b1;
    prev = busy;
    repeat (100) @(negedge clk) begin
      if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) bad++;
      if (busy && !prev) rises++;
      prev = busy;
    end
    checks++; if (bad != 0) $display("FAIL blank_out got %0d lit cycles expected 0", bad); else passed++;
    checks++; if (rises < 1) $display("FAIL blank_busy got %0d pulses expected at least 1", rises); else passed++;
    blank = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (an === 6'h3F) $display("FAIL unblank_an got %h expected one digit enabled", an); else passed++;
  endtask

  task automatic test_async_reset();
    bit a, b;
    int cnt;
    wait_busy(1'b0, 250, a);
    wait_busy(1'b1, 250, b);
    checks++; if (!(a && b)) $display("FAIL ar_start got timeout expected conversion"); else passed++;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (an !== 6'h3F) $display("FAIL ar_an got %h expected 3f", an); else passed++;
    checks++; if (seg !== 7'h7F) $display("FAIL ar_seg got %h expected 7f", seg); else passed++;
    checks++; if (dp !== 1'b1) $display("FAIL ar_dp got %b expected 1", dp); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL ar_busy got %b expected 0", busy); else passed++;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) @(negedge clk) if (busy) cnt++;
    checks++; if (cnt != 8) $display("FAIL ar_busy_len got %0d expected 8", cnt); else passed++;
    capture_frame();
    set_exp(1, 0, 2, 0, 3, 0);
    checks++; if (seen !== 6'h3F) $display("FAIL ar_slots got %b expected 111111", seen); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seen_seg[i] !== exp_seg[i]) $display("FAIL ar_seg slot%0d got %h expected %h", i, seen_seg[i], exp_seg[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_range();
    test_capture();
    test_blank();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
